// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// Holds the loader state encoding and default handshake words.
package program_loader_pkg;

    typedef enum logic [2:0] {
        WAIT_HDR,
        LOAD,
        SEND_SUM,
        SEND_ACK,
        RUN,
        SEND_ERR
    } loader_state_t;

    localparam logic [31:0] ACK_OK_DEF  = 32'h0000_00AA;
    localparam logic [31:0] ACK_ERR_DEF = 32'h0000_00EE;

    // A header is unusable when it is empty or larger than the memory.
    function automatic logic hdr_bad(
        input logic [31:0] n,
        input logic [31:0] depth
    );
        return (n == 32'd0) || (n > depth);
    endfunction

endpackage

// File: rtl/loader_sender.sv
// Single-word transmit handshake for the program loader.
// Launches a one-cycle send pulse when asked and the transmitter is free.
module loader_sender (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] word,
    input  logic        send_busy,
    output logic        send_en,
    output logic [31:0] send_content,
    output logic        done
);

    logic        en_q;
    logic        en_d;
    logic [31:0] data_q;
    logic [31:0] data_d;

    // Fire only from an idle cycle so pulses never touch each other.
    always_comb begin
        en_d   = req && !send_busy && !en_q;
        data_d = en_d ? word : 32'd0;
    end

    // Pulse and payload registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_q   <= 1'b0;
            data_q <= 32'd0;
        end else begin
            en_q   <= en_d;
            data_q <= data_d;
        end
    end

    assign send_en      = en_q;
    assign send_content = data_q;
    assign done         = en_q;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: header, payload into IMEM, checksum and ack.
// Releases the core once a full program has been written and acknowledged.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          IMEM_DEPTH = 16384,
    parameter logic [31:0] ACK_OK     = ACK_OK_DEF,
    parameter logic [31:0] ACK_ERR    = ACK_ERR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] recv_size,
    input  logic [31:0] recv_rd,
    output logic        recv_en,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    input  logic        send_busy,
    output logic        send_en,
    output logic [31:0] send_content,
    output logic        core_start,
    output logic [31:0] checksum
);

    loader_state_t state_q;
    loader_state_t state_d;
    logic [31:0]   cnt_q;
    logic [31:0]   cnt_d;
    logic [31:0]   len_q;
    logic [31:0]   len_d;
    logic [31:0]   sum_q;
    logic [31:0]   sum_d;
    logic          core_q;
    logic          core_d;

    logic          have_word;
    logic          hdr_pop;
    logic          wr_fire;
    logic          snd_req;
    logic [31:0]   snd_word;
    logic          snd_done;

    // Next-state, counter and checksum update.
    always_comb begin
        have_word = reset && (recv_size != 32'd0);
        hdr_pop   = have_word && (state_q == WAIT_HDR);
        wr_fire   = have_word && (state_q == LOAD);
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sum_d     = sum_q;
        unique case (state_q)
            WAIT_HDR: begin
                if (hdr_pop) begin
                    len_d = recv_rd;
                    if (hdr_bad(recv_rd, 32'(IMEM_DEPTH))) begin
                        state_d = SEND_ERR;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = 32'd0;
                        sum_d   = 32'd0;
                    end
                end
            end
            LOAD: begin
                if (wr_fire) begin
                    sum_d = sum_q + recv_rd;
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == len_q - 32'd1) begin
                        state_d = SEND_SUM;
                    end
                end
            end
            SEND_SUM: if (snd_done) state_d = SEND_ACK;
            SEND_ACK: if (snd_done) state_d = RUN;
            SEND_ERR: if (snd_done) state_d = WAIT_HDR;
            RUN:      state_d = RUN;
            default:  state_d = WAIT_HDR;
        endcase
        core_d = (state_d == RUN);
    end

    // Look ahead at the next state so the checksum goes out right after
    // the last write instead of idling a cycle in SEND_SUM first.
    always_comb begin
        snd_req  = 1'b1;
        snd_word = 32'd0;
        unique case (state_d)
            SEND_SUM: snd_word = sum_d;
            SEND_ACK: snd_word = ACK_OK;
            SEND_ERR: snd_word = ACK_ERR;
            default:  snd_req  = 1'b0;
        endcase
    end

    // Loader state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_HDR;
            cnt_q   <= 32'd0;
            len_q   <= 32'd0;
            sum_q   <= 32'd0;
            core_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            core_q  <= core_d;
        end
    end

    loader_sender u_sender (
        .clock        (clock),
        .reset        (reset),
        .req          (snd_req),
        .word         (snd_word),
        .send_busy    (send_busy),
        .send_en      (send_en),
        .send_content (send_content),
        .done         (snd_done)
    );

    assign recv_en    = hdr_pop | wr_fire;
    assign imem_we    = wr_fire;
    assign imem_waddr = wr_fire ? cnt_q : 32'd0;
    assign imem_wdata = wr_fire ? recv_rd : 32'd0;
    assign core_start = core_q;
    assign checksum   = (state_q == RUN) ? 32'd0 : sum_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader.
// Default-depth instance plus a depth-4 instance for the overflow edge.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        send_busy = 1'b0;
    logic        sel = 1'b0;
    logic        flush = 1'b0;

    logic [31:0] fifo [0:255];
    int          wp = 0;
    int          rp = 0;
    int          cyc = 0;
    logic [31:0] fsize;
    logic [31:0] frd;

    logic        recv_en_a, imem_we_a, send_en_a, core_a;
    logic [31:0] waddr_a, wdata_a, content_a, sum_a;
    logic        recv_en_b, imem_we_b, send_en_b, core_b;
    logic [31:0] waddr_b, wdata_b, content_b, sum_b;

    logic        recv_en, imem_we, send_en, core_start;
    logic [31:0] imem_waddr, imem_wdata, send_content, checksum;

    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];
    logic [31:0] snd_log[$];
    logic [31:0] snd_cyc[$];
    logic [31:0] sum_log[$];
    int          last_wr = 0;
    int          core_cyc = -1;
    int          consec = 0;
    logic        prev_en = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          len;
        logic [31:0] w [4];
        logic [31:0] sum;
    } vec_t;

    vec_t tbl [4];

    always #5 clock = ~clock;

    assign fsize = 32'(wp - rp);
    assign frd   = fifo[rp[7:0]];

    program_loader dut (
        .clock(clock), .reset(reset),
        .recv_size(sel ? 32'd0 : fsize), .recv_rd(frd),
        .recv_en(recv_en_a), .imem_we(imem_we_a),
        .imem_waddr(waddr_a), .imem_wdata(wdata_a),
        .send_busy(send_busy), .send_en(send_en_a),
        .send_content(content_a), .core_start(core_a),
        .checksum(sum_a)
    );

    program_loader #(.IMEM_DEPTH(4)) dut4 (
        .clock(clock), .reset(reset),
        .recv_size(sel ? fsize : 32'd0), .recv_rd(frd),
        .recv_en(recv_en_b), .imem_we(imem_we_b),
        .imem_waddr(waddr_b), .imem_wdata(wdata_b),
        .send_busy(send_busy), .send_en(send_en_b),
        .send_content(content_b), .core_start(core_b),
        .checksum(sum_b)
    );

    assign recv_en      = sel ? recv_en_b : recv_en_a;
    assign imem_we      = sel ? imem_we_b : imem_we_a;
    assign imem_waddr   = sel ? waddr_b : waddr_a;
    assign imem_wdata   = sel ? wdata_b : wdata_a;
    assign send_en      = sel ? send_en_b : send_en_a;
    assign send_content = sel ? content_b : content_a;
    assign core_start   = sel ? core_b : core_a;
    assign checksum     = sel ? sum_b : sum_a;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (flush) rp <= 0;
        else if (recv_en) rp <= rp + 1;
    end

    always @(negedge clock) begin
        if (reset) begin
            if (imem_we) begin
                wa_log.push_back(imem_waddr);
                wd_log.push_back(imem_wdata);
                last_wr = cyc;
            end
            if (send_en) begin
                snd_log.push_back(send_content);
                snd_cyc.push_back(32'(cyc));
                sum_log.push_back(checksum);
                if (prev_en) consec++;
            end
            prev_en = send_en;
            if (core_start && core_cyc < 0) core_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$],
                                        input int i);
        return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifo[wp[7:0]] = w;
        wp++;
    endtask

    task automatic clear_logs();
        wa_log.delete();
        wd_log.delete();
        snd_log.delete();
        snd_cyc.delete();
        sum_log.delete();
        core_cyc = -1;
        consec = 0;
        prev_en = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        flush = 1'b1;
        wp = 0;
        clear_logs();
        tick();
        flush = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_core(input string name);
        int n = 0;
        while (!core_start && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_core_start"}, 32'(core_start), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_ok_sends(input string name,
                                input logic [31:0] sum);
        chk({name, "_nsend"}, 32'(snd_log.size()), 32'd2);
        chk({name, "_sum"}, qat(snd_log, 0), sum);
        chk({name, "_ack"}, qat(snd_log, 1), 32'hAA);
        chk({name, "_b2b"}, 32'(consec), 32'd0);
    endtask

    initial begin
        tbl[0].len = 3;
        tbl[0].w   = '{32'd1, 32'd2, 32'd3, 32'd0};
        tbl[0].sum = 32'h6;
        tbl[1].len = 1;
        tbl[1].w   = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
        tbl[1].sum = 32'hFFFF_FFFF;
        tbl[2].len = 4;
        tbl[2].w   = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd2};
        tbl[2].sum = 32'h3;
        tbl[3].len = 2;
        tbl[3].w   = '{32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0};
        tbl[3].sum = 32'hF0E2_1567;

        // Reset state, with a word waiting in the FIFO.
        push(32'd3);
        repeat (2) @(negedge clock);
        chk("rst_recv_en", 32'(recv_en), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_send_en", 32'(send_en), 32'd0);
        chk("rst_content", send_content, 32'd0);
        chk("rst_core", 32'(core_start), 32'd0);
        chk("rst_checksum", checksum, 32'd0);

        // Table-driven back-to-back loads.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push(32'(tbl[v].len));
            for (int i = 0; i < tbl[v].len; i++) push(tbl[v].w[i]);
            push(32'h55);
            wait_core($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_nwr", v), 32'(wa_log.size()),
                32'(tbl[v].len));
            for (int i = 0; i < tbl[v].len; i++) begin
                chk($sformatf("vec%0d_addr%0d", v, i), qat(wa_log, i),
                    32'(i));
                chk($sformatf("vec%0d_data%0d", v, i), qat(wd_log, i),
                    tbl[v].w[i]);
            end
            chk_ok_sends($sformatf("vec%0d", v), tbl[v].sum);
            chk($sformatf("vec%0d_cksum_out", v), qat(sum_log, 0),
                tbl[v].sum);
            chk($sformatf("vec%0d_sum_lat", v), qat(snd_cyc, 0),
                32'(last_wr + 1));
            chk($sformatf("vec%0d_core_lat", v), 32'(core_cyc),
                qat(snd_cyc, 1) + 32'd1);
            chk($sformatf("vec%0d_left", v), fsize, 32'd1);
            chk($sformatf("vec%0d_run_recv", v), 32'(recv_en), 32'd0);
            chk($sformatf("vec%0d_run_cksum", v), checksum, 32'd0);
        end

        // Bad header, then a good one.
        do_reset();
        push(32'd0);
        push(32'd1);
        push(32'hFFFF_FFFF);
        wait_core("badhdr");
        chk("badhdr_nsend", 32'(snd_log.size()), 32'd3);
        chk("badhdr_err", qat(snd_log, 0), 32'hEE);
        chk("badhdr_err_cksum", qat(sum_log, 0), 32'd0);
        chk("badhdr_sum", qat(snd_log, 1), 32'hFFFF_FFFF);
        chk("badhdr_ack", qat(snd_log, 2), 32'hAA);
        chk("badhdr_addr0", qat(wa_log, 0), 32'd0);

        // Gap between payload words.
        do_reset();
        push(32'd2);
        push(32'd10);
        repeat (7) tick();
        @(negedge clock);
        chk("gap_nwr_mid", 32'(wa_log.size()), 32'd1);
        chk("gap_we_mid", 32'(imem_we), 32'd0);
        tick();
        push(32'd20);
        wait_core("gap");
        chk("gap_nwr", 32'(wa_log.size()), 32'd2);
        chk("gap_addr1", qat(wa_log, 1), 32'd1);
        chk("gap_data1", qat(wd_log, 1), 32'd20);
        chk_ok_sends("gap", 32'd30);

        // Busy transmitter after the load.
        do_reset();
        send_busy = 1'b1;
        push(32'd2);
        push(32'd5);
        push(32'd6);
        repeat (3) tick();
        repeat (10) tick();
        @(negedge clock);
        chk("busy_nwr", 32'(wa_log.size()), 32'd2);
        chk("busy_nsend_held", 32'(snd_log.size()), 32'd0);
        tick();
        send_busy = 1'b0;
        wait_core("busy");
        chk_ok_sends("busy", 32'd11);
        chk("busy_gap", 32'((qat(snd_cyc, 1) - qat(snd_cyc, 0)) >= 2),
            32'd1);

        // Reset in the middle of a load.
        do_reset();
        push(32'd4);
        push(32'd100);
        push(32'd200);
        repeat (4) tick();
        @(negedge clock);
        chk("mid_nwr", 32'(wa_log.size()), 32'd2);
        chk("mid_cksum", checksum, 32'd300);
        tick();
        reset = 1'b0;
        clear_logs();
        push(32'd2);
        push(32'd7);
        push(32'd8);
        @(negedge clock);
        chk("mid_rst_recv", 32'(recv_en), 32'd0);
        chk("mid_rst_we", 32'(imem_we), 32'd0);
        chk("mid_rst_cksum", checksum, 32'd0);
        chk("mid_rst_send", 32'(send_en), 32'd0);
        tick();
        reset = 1'b1;
        wait_core("mid");
        chk("mid_nwr2", 32'(wa_log.size()), 32'd2);
        chk("mid_addr0", qat(wa_log, 0), 32'd0);
        chk("mid_data0", qat(wd_log, 0), 32'd7);
        chk("mid_addr1", qat(wa_log, 1), 32'd1);
        chk("mid_data1", qat(wd_log, 1), 32'd8);
        chk_ok_sends("mid", 32'd15);

        // Depth limit on the small instance.
        sel = 1'b1;
        do_reset();
        push(32'd5);
        push(32'd4);
        push(32'd1);
        push(32'd2);
        push(32'd3);
        push(32'd4);
        wait_core("ovf");
        chk("ovf_nsend", 32'(snd_log.size()), 32'd3);
        chk("ovf_err", qat(snd_log, 0), 32'hEE);
        chk("ovf_nwr", 32'(wa_log.size()), 32'd4);
        chk("ovf_last_addr", qat(wa_log, 3), 32'd3);
        chk("ovf_last_data", qat(wd_log, 3), 32'd4);
        chk("ovf_sum", qat(snd_log, 1), 32'd10);
        chk("ovf_ack", qat(snd_log, 2), 32'hAA);
        chk("ovf_b2b", 32'(consec), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 16384; instruction-memory capacity in words; legal program lengths are 1..IMEM_DEPTH.
REQ-002 Parameter ACK_OK, default 32'h000000AA; word sent after a successful load.
REQ-003 Parameter ACK_ERR, default 32'h000000EE; word sent after a rejected header.
REQ-004 clock  input  1  single clock for the block; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-006 recv_size  input  32  receive-FIFO word count; the head word is valid when recv_size>0.
REQ-007 recv_rd  input  32  receive-FIFO head word (combinational).
REQ-008 recv_en  output  1  pops one word from the receive FIFO in the cycle it is high.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_waddr  output  32  word address for the instruction-memory write.
REQ-011 imem_wdata  output  32  data for the instruction-memory write.
REQ-012 send_busy  input  1  transmitter cannot accept a word.
REQ-013 send_en  output  1  one-cycle pulse; the transmitter accepts send_content.
REQ-014 send_content  output  32  word to transmit; stable while send_en=1.
REQ-015 core_start  output  1  level signal; high releases the core to fetch from address 0.
REQ-016 checksum  output  32  running sum of loaded words, mod 2^32.

Function
REQ-017 The block SHALL implement the state machine WAIT_HDR -> LOAD -> SEND_SUM -> SEND_ACK -> RUN, plus SEND_ERR.
REQ-018 WAIT_HDR: when recv_size>0, the block SHALL pop one word (recv_en=1, combinational with recv_size>0) and latch it as length N.
REQ-019 N=0 or N>IMEM_DEPTH: the next state SHALL be SEND_ERR; otherwise LOAD, with the word counter and checksum cleared.
REQ-020 LOAD: each cycle with recv_size>0, the block SHALL assert recv_en, imem_we=1, imem_waddr=counter, imem_wdata=recv_rd, add recv_rd to checksum, and increment counter.
REQ-021 LOAD with recv_size=0: recv_en=0, imem_we=0, counter holds; no timeout.
REQ-022 The write for the last word (counter=N-1) SHALL transition to SEND_SUM in the same edge.
REQ-023 Addresses SHALL run 0..N-1 without wrap; a maximum-length load ends exactly at address IMEM_DEPTH-1.
REQ-024 recv_en SHALL be 0 in every state other than WAIT_HDR and LOAD; words arriving after N are left in the FIFO.
REQ-025 Send rule, in SEND_SUM, SEND_ACK and SEND_ERR: when send_busy=0 and send_en is currently 0, the block SHALL register send_en=1 and send_content for exactly one cycle, then advance.
REQ-026 Send rule: send_en SHALL never be high on two consecutive cycles.
REQ-027 SEND_SUM SHALL transmit checksum and then go to SEND_ACK.
REQ-028 SEND_ACK SHALL transmit ACK_OK and then go to RUN.
REQ-029 SEND_ERR SHALL transmit ACK_ERR and then return to WAIT_HDR, with the checksum unchanged.
REQ-030 RUN SHALL hold core_start=1 permanently until reset; all other outputs are 0 in RUN.
REQ-031 imem_we SHALL be registered-free (combinational from state and recv_size) so that a write and its pop coincide.
REQ-032 Latency: the first memory write occurs no earlier than 1 cycle after the header pop; back-to-back words SHALL sustain 1 word per cycle.
REQ-033 Latency: the checksum send_en SHALL occur 1 cycle after the last write if send_busy=0.

Reset
REQ-034 Asserting reset at any time, including mid-LOAD or mid-send, SHALL immediately force: state=WAIT_HDR, counter=0, N=0, checksum=0, send_en=0, send_content=0, core_start=0.
REQ-035 While reset=0, recv_en=0 and imem_we=0.
REQ-036 A partial load interrupted by reset is discarded, and the next received word is treated as a header.

Structure
REQ-037 A shared package SHALL hold the state enum (loader_state_t) and the default ACK_OK/ACK_ERR constants.
REQ-038 One sub-module, loader_sender, SHALL implement the single-word send handshake (REQ-025, REQ-026), with inputs req/word and output done.

Verification
REQ-039 Normal load: header 3, words 1, 2, 3 back-to-back, send_busy=0 -> writes to addresses 0..2; send 32'h6, then 32'hAA; core_start=1 the cycle after the AA send.
REQ-040 Bad header: header 0 -> send 32'hEE; then header 1, word 32'hFFFFFFFF -> send 32'hFFFFFFFF, then 32'hAA.
REQ-041 Gapped input: header 2, with recv_size=0 for 5 cycles between the words -> no spurious imem_we; counter holds; checksum correct.
REQ-042 Busy transmitter: send_busy=1 for 10 cycles after the load -> send_en stays 0 and then pulses once per word; checksum, then ACK, in order.
REQ-043 Reset mid-load: header 4, 2 words, reset low for 1 cycle -> all outputs 0; next word 2 plus words 7, 8 loads at addresses 0..1 with checksum 15.
REQ-044 Overflow boundary: IMEM_DEPTH=4, header 5 -> 32'hEE; header 4 -> last write to address 3, then the ACK sequence.
